bin_to_bcd_seq: RTL and testbench

//  Parametrised, multi-cycle binary-to-BCD converter (shift-and-add-3), one bit per clock.

---
 rtl/bin_to_bcd_pkg.sv | 25 ++
 rtl/bin_to_bcd_seq_if.sv | 24 ++
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 145 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    // Converter FSM: waiting for a request, or shifting one bit per clock.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default input width and the matching bit-counter width.
    localparam int BIN_W_DEFAULT = 16;
    localparam int CNT_W         = $clog2(BIN_W_DEFAULT + 1);

    // Decimal digits needed for an unsigned bin_w-bit value: ceil(bin_w*log10(2)).
    // Uses integer fixed point with log10(2) ~= 0.30103.
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

    // Bits needed to hold a bit count from 0 up to bin_w inclusive.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle for bin_to_bcd_seq: start/bin in, busy/done/bcd/blank out.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    // Requester side drives start/bin and observes the result.
    modport master (
        output start, bin,
        input  busy, done, bcd, blank
    );

    // Converter side.
    modport slave (
        input  start, bin,
        output busy, done, bcd, blank
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// One shift-and-add-3 correction cell: a BCD digit of 5..9 gets +3 before the
// shift so the doubled value carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);
    // Pure combinational correction; 4-bit wrap is never reached for legal digits.
    assign d_out = (d_in >= 4'd5) ? (d_in + 4'd3) : d_in;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// A request is taken on start while idle; the result appears with a one-cycle
// done pulse BIN_W clocks later and is held until the next completion.
// Optional feature macro: BIN2BCD_BLANK_EN enables the leading-zero blank mask;
// without it blank is tied to zero and no blanking logic exists.
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    bin_to_bcd_seq_if.slave bus
);
    localparam int BCD_W    = 4 * DIGITS;
    localparam int CNT_BITS = cnt_width(BIN_W);

    // Parameter sanity: reject configurations that cannot hold the full range.
    if (BIN_W < 4) begin : g_bad_bin_w
        $error("bin_to_bcd_seq: BIN_W must be at least 4");
    end
    if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     shreg_q, shreg_d;
    logic [BCD_W-1:0]     work_q,  work_d;
    logic [CNT_BITS-1:0]  cnt_q,   cnt_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic [BCD_W-1:0]     bcd_q,   bcd_d;

    logic [BCD_W-1:0]     work_adj;
    logic [BCD_W-1:0]     work_shifted;
    logic                 unused_adj_msb;

    // Per-digit add-3 correction applied to the working BCD before each shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (work_q[4*gi +: 4]),
            .d_out (work_adj[4*gi +: 4])
        );
    end

    // The shift pushes the top bit out; DIGITS is sized so it is always zero.
    assign work_shifted   = {work_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
    assign unused_adj_msb = work_adj[BCD_W-1];

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic [DIGITS-1:0] blank_final;

    // Digit k blanks when it and every higher digit are zero; units never blank.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_units
            assign blank_final[gi] = 1'b0;
        end else begin : g_upper
            assign blank_final[gi] = ~(|work_shifted[BCD_W-1:4*gi]);
        end
    end
`endif

    // Next-state and datapath computation for FSM, counter and result registers.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
`ifdef BIN2BCD_BLANK_EN
        blank_d = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shreg_d = bus.bin;
                    work_d  = '0;
                    cnt_d   = CNT_BITS'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d  = work_shifted;
                shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_BITS'(1);
                // Last bit shifted in: publish the result and return to idle.
                if (cnt_q == CNT_BITS'(1)) begin
                    bcd_d   = work_shifted;
`ifdef BIN2BCD_BLANK_EN
                    blank_d = blank_final;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
`ifdef BIN2BCD_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
`ifdef BIN2BCD_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
`ifdef BIN2BCD_BLANK_EN
    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases plus random traffic
// compared every cycle against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
    localparam int BW = 16;
    localparam int DG = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(BW), .DIGITS(DG)) bus ();
    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3))  bus8 ();

    bin_to_bcd_seq #(.BIN_W(BW), .DIGITS(DG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion: plain decimal digit extraction.
    function automatic logic [4*DG-1:0] ref_bcd(input longint v);
        logic [4*DG-1:0] r;
        longint p;
        r = '0;
        p = 1;
        for (int k = 0; k < DG; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Reference blank mask: digit k (k>=1) is a leading zero iff v < 10^k.
    function automatic logic [DG-1:0] ref_blank(input longint v);
        logic [DG-1:0] r;
        longint p;
        r = '0;
`ifdef BIN2BCD_BLANK_EN
        p = 10;
        for (int k = 1; k < DG; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
`else
        p = v;
`endif
        return r;
    endfunction

    // Behavioural model: a request taken when idle completes BW clocks later.
    logic            m_busy = 1'b0;
    logic            m_done = 1'b0;
    logic [4*DG-1:0] m_bcd  = '0;
    logic [DG-1:0]   m_blank = '0;
    longint          m_val  = 0;
    int              m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_bcd   = '0;
            m_blank = '0;
            m_left  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_bcd   = ref_bcd(m_val);
                    m_blank = ref_blank(m_val);
                end
            end else if (bus.start) begin
                m_busy = 1'b1;
                m_val  = longint'(bus.bin);
                m_left = BW;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", bus.busy, m_busy);
            check("done", bus.done, m_done);
            check("bcd", bus.bcd, m_bcd);
            check("blank", bus.blank, m_blank);
            if (bus.done) begin
                logic bad;
                bad = 1'b0;
                for (int k = 0; k < DG; k++) begin
                    if (bus.bcd[4*k +: 4] > 4'd9) bad = 1'b1;
                end
                check("digit_le_9", bad, 1'b0);
            end
        end
    end

    task automatic start_conv(input logic [BW-1:0] v);
        @(negedge clk);
        bus.bin   = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; returns negedges elapsed and busy-high count.
    task automatic wait_done(output int lat, output int busy_n);
        logic ok;
        lat = 0;
        busy_n = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 40 cycles, required a done pulse");
        end
    endtask

    initial begin
        int lat, busy_n, dones, d1, d2, d3;
        logic [4*DG-1:0] got;
        logic [DG-1:0] exp_blank0, exp_blank1234, exp_blank42;

        bus.start  = 1'b0;
        bus.bin    = '0;
        bus8.start = 1'b0;
        bus8.bin   = '0;

`ifdef BIN2BCD_BLANK_EN
        exp_blank0    = 5'b11110;
        exp_blank1234 = 5'b10000;
        exp_blank42   = 5'b11100;
`else
        exp_blank0    = 5'b00000;
        exp_blank1234 = 5'b00000;
        exp_blank42   = 5'b00000;
`endif

        // Pin the reference model with hand-computed values.
        check("model_bcd_65535", ref_bcd(65535), 20'h65535);
        check("model_bcd_1234", ref_bcd(1234), 20'h01234);
        check("model_blank_42", ref_blank(42), exp_blank42);

        // Reset state.
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_bcd", bus.bcd, '0);
        check("rst_blank", bus.blank, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero input: latency and blank mask.
        start_conv(16'd0);
        wait_done(lat, busy_n);
        $display("conv 0: lat=%0d busy=%0d bcd=%h blank=%b", lat, busy_n, bus.bcd, bus.blank);
        check("zero_latency", 32'(lat), 32'(BW + 1));
        check("zero_bcd", bus.bcd, 20'h00000);
        check("zero_blank", bus.blank, exp_blank0);

        // Maximum input.
        start_conv(16'hFFFF);
        wait_done(lat, busy_n);
        $display("conv 65535: lat=%0d busy=%0d bcd=%h blank=%b", lat, busy_n, bus.bcd, bus.blank);
        check("max_bcd", bus.bcd, 20'h65535);
        check("max_blank", bus.blank, 5'b00000);
        check("max_busy_cycles", 32'(busy_n), 32'(BW));

        // Ordinary values.
        start_conv(16'd1234);
        wait_done(lat, busy_n);
        $display("conv 1234: bcd=%h blank=%b", bus.bcd, bus.blank);
        check("v1234_bcd", bus.bcd, 20'h01234);
        check("v1234_blank", bus.blank, exp_blank1234);
        start_conv(16'd42);
        wait_done(lat, busy_n);
        $display("conv 42: bcd=%h blank=%b", bus.bcd, bus.blank);
        check("v42_bcd", bus.bcd, 20'h00042);
        check("v42_blank", bus.blank, exp_blank42);

        // Starts while busy are ignored.
        start_conv(16'd321);
        dones = 0;
        got = '0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                got = bus.bcd;
            end
            if (c == 3 || c == 9) begin
                bus.start = 1'b1;
                bus.bin   = 16'd999;
            end else begin
                bus.start = 1'b0;
            end
        end
        $display("busy-start test: dones=%0d bcd=%h", dones, got);
        check("ignore_dones", 32'(dones), 32'd1);
        check("ignore_bcd", got, 20'h00321);

        // Reset in the middle of a conversion.
        start_conv(16'd4321);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_bcd", bus.bcd, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        $display("mid-reset: dones after reset=%0d", dones);
        check("midrst_no_done", 32'(dones), 32'd0);
        start_conv(16'd500);
        wait_done(lat, busy_n);
        $display("conv 500: bcd=%h", bus.bcd);
        check("after_rst_bcd", bus.bcd, 20'h00500);

        // Back-to-back with start held high.
        @(negedge clk);
        bus.bin   = 16'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.bin = 16'd10;
        wait_done(lat, busy_n);
        d1 = cyc;
        check("b2b_9", bus.bcd, 20'h00009);
        @(posedge clk);
        #1 bus.bin = 16'd99;
        wait_done(lat, busy_n);
        d2 = cyc;
        check("b2b_10", bus.bcd, 20'h00010);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, busy_n);
        d3 = cyc;
        check("b2b_99", bus.bcd, 20'h00099);
        $display("back-to-back: done cycles %0d %0d %0d", d1, d2, d3);
        check("b2b_period1", 32'(d2 - d1), 32'(BW + 1));
        check("b2b_period2", 32'(d3 - d2), 32'(BW + 1));

        // Narrow configuration: 8-bit input, 3 digits.
        @(negedge clk);
        bus8.bin   = 8'd255;
        bus8.start = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus8.done) break;
        end
        $display("conv8 255: lat=%0d bcd=%h blank=%b", lat, bus8.bcd, bus8.blank);
        check("w8_latency", 32'(lat), 32'd9);
        check("w8_bcd", bus8.bcd, 12'h255);
        check("w8_blank", bus8.blank, 3'b000);

        // Random traffic; the per-cycle compare process does the checking.
        dones = 0;
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) != 0);
            bus.bin   = BW'($urandom);
            if ($urandom_range(0, 15) == 0) bus.bin = 16'hFFFF;
            if ($urandom_range(0, 15) == 1) bus.bin = BW'($urandom_range(0, 20));
            if (bus.done) dones++;
        end
        bus.start = 1'b0;
        repeat (BW + 2) @(negedge clk);
        $display("random phase: %0d conversions completed", dones);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
